// File: rtl/csr_wb_regfile.sv
// Writeback-stage consumer: passes GPR writes through, holds the machine-mode CSRs and counters,
// and serves a write-first CSR read port to EX.
module csr_wb_regfile #(
  parameter int unsigned      XLEN        = 64,
  parameter int unsigned      CSR_AW      = 12,
  parameter logic [XLEN-1:0]  RST_MSTATUS = XLEN'(64'h1800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  input  logic              csr_wvalid_i,
  input  logic [XLEN-1:0]   trap_mstatus_wdata_i,
  input  logic              trap_mstatus_wvalid_i,
  input  logic [XLEN-1:0]   trap_mepc_wdata_i,
  input  logic              trap_mepc_wvalid_i,
  input  logic [XLEN-1:0]   trap_mcause_wdata_i,
  input  logic              trap_mcause_wvalid_i,
  input  logic [XLEN-1:0]   trap_mtval_wdata_i,
  input  logic              trap_mtval_wvalid_i,
  input  logic [XLEN-1:0]   trap_mtvec_wdata_i,
  input  logic              trap_mtvec_wvalid_i,
  output logic              gpr_wen_o,
  output logic [4:0]        gpr_waddr_o,
  output logic [XLEN-1:0]   gpr_wdata_o,
  input  logic [CSR_AW-1:0] csr_raddr_i,
  output logic [XLEN-1:0]   csr_rdata_o,
  output logic              csr_illegal_o,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic              mstatus_mie_o
);

  localparam logic [CSR_AW-1:0] A_MSTATUS  = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MTVEC    = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MSCRATCH = CSR_AW'(12'h340);
  localparam logic [CSR_AW-1:0] A_MEPC     = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE   = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] A_MTVAL    = CSR_AW'(12'h343);
  localparam logic [CSR_AW-1:0] A_MCYCLE   = CSR_AW'(12'hB00);
  localparam logic [CSR_AW-1:0] A_MINSTRET = CSR_AW'(12'hB02);

  // Only MIE/MPIE are storable; MPP is hardwired to machine mode.
  localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(64'h88);
  localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'(64'h1800);
  localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'(64'h2);
  localparam logic [XLEN-1:0] MEPC_WMASK    = ~XLEN'(64'h3);

  logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] mcycle_view, minstret_view;
  logic [XLEN-1:0] mstatus_src, mtvec_src, mepc_src, mcause_src, mtval_src;
  logic            gen_mstatus, gen_mtvec, gen_mscratch, gen_mepc, gen_mcause, gen_mtval;
  logic            gen_mcycle, gen_minstret;

  assign gpr_wen_o   = (rd_addr_i != 5'd0);
  assign gpr_waddr_o = rd_addr_i;
  assign gpr_wdata_o = mem_data_i;

  assign gen_mstatus  = csr_wvalid_i && (csr_addr_i == A_MSTATUS);
  assign gen_mtvec    = csr_wvalid_i && (csr_addr_i == A_MTVEC);
  assign gen_mscratch = csr_wvalid_i && (csr_addr_i == A_MSCRATCH);
  assign gen_mepc     = csr_wvalid_i && (csr_addr_i == A_MEPC);
  assign gen_mcause   = csr_wvalid_i && (csr_addr_i == A_MCAUSE);
  assign gen_mtval    = csr_wvalid_i && (csr_addr_i == A_MTVAL);
  assign gen_mcycle   = csr_wvalid_i && (csr_addr_i == A_MCYCLE);
  assign gen_minstret = csr_wvalid_i && (csr_addr_i == A_MINSTRET);

  // Trap bundle overrides the generic write when both target the same CSR.
  assign mstatus_src = trap_mstatus_wvalid_i ? trap_mstatus_wdata_i : csr_wdata_i;
  assign mtvec_src   = trap_mtvec_wvalid_i   ? trap_mtvec_wdata_i   : csr_wdata_i;
  assign mepc_src    = trap_mepc_wvalid_i    ? trap_mepc_wdata_i    : csr_wdata_i;
  assign mcause_src  = trap_mcause_wvalid_i  ? trap_mcause_wdata_i  : csr_wdata_i;
  assign mtval_src   = trap_mtval_wvalid_i   ? trap_mtval_wdata_i   : csr_wdata_i;

  assign mstatus_d  = (trap_mstatus_wvalid_i || gen_mstatus) ?
                      ((mstatus_src & MSTATUS_WMASK) | MSTATUS_FIXED) : mstatus_q;
  assign mtvec_d    = (trap_mtvec_wvalid_i || gen_mtvec) ? (mtvec_src & MTVEC_WMASK) : mtvec_q;
  assign mepc_d     = (trap_mepc_wvalid_i || gen_mepc) ? (mepc_src & MEPC_WMASK) : mepc_q;
  assign mcause_d   = (trap_mcause_wvalid_i || gen_mcause) ? mcause_src : mcause_q;
  assign mtval_d    = (trap_mtval_wvalid_i || gen_mtval) ? mtval_src : mtval_q;
  assign mscratch_d = gen_mscratch ? csr_wdata_i : mscratch_q;

  assign mcycle_d      = gen_mcycle ? csr_wdata_i : mcycle_q + XLEN'(1);
  assign minstret_d    = gen_minstret ? csr_wdata_i :
                         ((|pc_i) ? minstret_q + XLEN'(1) : minstret_q);
  // Counters bypass only an explicit write, never their own increment.
  assign mcycle_view   = gen_mcycle ? csr_wdata_i : mcycle_q;
  assign minstret_view = gen_minstret ? csr_wdata_i : minstret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= RST_MSTATUS;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      A_MSTATUS:  csr_rdata_o = mstatus_d;
      A_MTVEC:    csr_rdata_o = mtvec_d;
      A_MSCRATCH: csr_rdata_o = mscratch_d;
      A_MEPC:     csr_rdata_o = mepc_d;
      A_MCAUSE:   csr_rdata_o = mcause_d;
      A_MTVAL:    csr_rdata_o = mtval_d;
      A_MCYCLE:   csr_rdata_o = mcycle_view;
      A_MINSTRET: csr_rdata_o = minstret_view;
      default:    csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_mie_o = mstatus_q[3];

endmodule
